// File: rtl/element_ranker_pkg.sv
// rtl/element_ranker_pkg.sv - shared constants, state type and pair tables for element_ranker
package element_ranker_pkg;

    localparam int NUM_ELEMS = 4;
    localparam int RANK_W    = 2;
    localparam int NUM_PAIRS = 6;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Packed so that index p selects pair p: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3)
    localparam logic [NUM_PAIRS-1:0][RANK_W-1:0] PAIR_I = {2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    localparam logic [NUM_PAIRS-1:0][RANK_W-1:0] PAIR_J = {2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1};

endpackage

// File: rtl/element_ranker_if.sv
// rtl/element_ranker_if.sv - operand load, rank result and status signals of element_ranker
interface element_ranker_if #(
    parameter int MAX_NUM_SIZE = 32
);
    logic [MAX_NUM_SIZE-1:0] data_in;
    logic                    valid_in;
    logic                    ready_out;
    logic [7:0]              ranks_out;
    logic                    valid_out;
    logic                    ready_in;
    logic                    busy_out;

    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, ranks_out, valid_out, busy_out
    );

    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, ranks_out, valid_out, busy_out
    );
endinterface

// File: rtl/element_ranker.sv
// rtl/element_ranker.sv - serial 4-operand loader that ranks every slot with one compare per cycle
module element_ranker
    import element_ranker_pkg::*;
#(
    parameter int MAX_NUM_SIZE = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    element_ranker_if.slave   bus
);

    state_t state, next_state;

    logic [RANK_W-1:0]       cnt;
    logic [2:0]              p;
    logic [MAX_NUM_SIZE-1:0] slot [NUM_ELEMS];
    logic [RANK_W-1:0]       rank [NUM_ELEMS];

    logic              accept;
    logic [RANK_W-1:0] pi, pj;
    logic              j_lt_i;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= LOAD;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        bus.ready_out = 1'b0;
        bus.valid_out = 1'b0;
        bus.busy_out  = 1'b1;
        case (state)
            LOAD: begin
                bus.ready_out = 1'b1;
                bus.busy_out  = 1'b0;
                if (bus.valid_in && (cnt == RANK_W'(NUM_ELEMS - 1))) next_state = COMPARE;
            end
            COMPARE: begin
                if (p == 3'(NUM_PAIRS - 1)) next_state = DONE;
            end
            DONE: begin
                bus.valid_out = 1'b1;
                if (bus.ready_in) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    assign accept = bus.valid_in && bus.ready_out;
    assign pi     = PAIR_I[p];
    assign pj     = PAIR_J[p];
    // Strict less-than: on a tie the lower slot index takes the lower rank
    assign j_lt_i = slot[pj] < slot[pi];

    // Operand storage carries no reset; its contents only matter once all slots are loaded
    always_ff @(posedge clk_in) begin
        if (accept) slot[cnt] <= bus.data_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
            p   <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) rank[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == RANK_W'(NUM_ELEMS - 1)) begin
                            p <= '0;
                            for (int i = 0; i < NUM_ELEMS; i++) rank[i] <= '0;
                        end
                    end
                end
                COMPARE: begin
                    if (j_lt_i) rank[pi] <= rank[pi] + 2'd1;
                    else        rank[pj] <= rank[pj] + 2'd1;
                    p <= (p == 3'(NUM_PAIRS - 1)) ? 3'd0 : p + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ranks_out = '0;
        for (int i = 0; i < NUM_ELEMS; i++) bus.ranks_out[RANK_W*i +: RANK_W] = rank[i];
    end

endmodule
